rvv_wb_collect: RTL

RVV_WB_COLLECT -- requirements
Module: rvv_wb_collect

---
 rtl/rvv_pkg.sv | 36 +++
 rtl/rvv_be_gen.sv | 34 +++
 rtl/rvv_wb_collect.sv | 117 +++++++++++
 3 files changed

// File: rtl/rvv_pkg.sv
// Shared definitions for the vector write-back collector: FSM state
// encoding, element-width and operand-type codes, latched instruction
// context, and a helper that clamps the element-width code.
package rvv_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Element width codes (element width = 8 << vsew bits)
  localparam logic [2:0] VSEW_8  = 3'd0;
  localparam logic [2:0] VSEW_16 = 3'd1;
  localparam logic [2:0] VSEW_32 = 3'd2;
  localparam logic [2:0] VSEW_64 = 3'd3;

  // Operand type codes
  localparam logic [2:0] OP_VV = 3'b001;
  localparam logic [2:0] OP_VX = 3'b010;
  localparam logic [2:0] OP_VI = 3'b100;

  // Instruction fields captured when a start is accepted
  typedef struct packed {
    logic [4:0] vd;
    logic [9:0] vl;
    logic [2:0] vsew;
    logic       mask;
  } wb_ctx_t;

  // Codes above 64-bit elements are treated as 64-bit elements
  function automatic logic [1:0] sew_clamp(input logic [2:0] code);
    return (code > VSEW_64) ? 2'd3 : code[1:0];
  endfunction

endpackage

// File: rtl/rvv_be_gen.sv
// Byte-enable generator: turns the element count, element width and the
// mask-op flag into per-byte write enables for the destination register.
// Bytes beyond the active region stay disabled (tail-undisturbed).
module rvv_be_gen
  import rvv_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic [9:0]          vl,
  input  logic [2:0]          vsew,
  input  logic                instr_mask,
  output logic [VLEN/8-1:0]   be
);

  logic [15:0] active_raw;
  logic [15:0] active;
  logic [2:0]  shamt;

  // Active bit count clamped to the register width, then thermometer-coded into bytes
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    shamt      = {1'b0, sew_clamp(vsew)} + 3'd3;
    active_raw = '0;
    active     = '0;
    be         = '0;
    if (instr_mask) active_raw = 16'(vl);
    else            active_raw = 16'(vl) << shamt;
    active = (active_raw > 16'(VLEN)) ? 16'(VLEN) : active_raw;
    for (int i = 0; i < VLEN/8; i++) begin
      be[i] = (16'(8*i) < active);
    end
  end

endmodule

// File: rtl/rvv_wb_collect.sv
// Vector write-back collector: gathers ALU lane chunks (or single mask
// bits) into a VLEN-wide buffer, then issues one register-file write with
// byte enables covering only the active elements.
module rvv_wb_collect
  import rvv_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4:0]          vd_addr,
  input  logic [9:0]          vl,
  input  logic [2:0]          vsew,
  input  logic                instr_mask,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         in_data,
  input  logic [9:0]          in_index,
  input  logic                in_last,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [4:0]          wb_addr,
  output logic [VLEN-1:0]     wb_data,
  output logic [VLEN/8-1:0]   wb_be,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CW = 1 << LANE_WIDTH;

  logic [1:0]      state_q, state_d;
  wb_ctx_t         ctx_q;
  logic [VLEN-1:0] buf_q;
  logic            err_q;

  logic            start_acc;
  logic            chunk_acc;
  logic            out_of_range;
  logic [VLEN-1:0] field_mask;
  logic [VLEN-1:0] field_data;
  logic            unused_in_data;

  assign start_acc = start && (state_q == ST_IDLE);
  assign chunk_acc = in_valid && in_ready;

  // Upper lane bits are legitimately ignored for narrow lanes and mask ops
  assign unused_in_data = ^in_data;

  // A chunk must fit entirely inside the register; otherwise it is dropped
  assign out_of_range = ctx_q.mask ? ({1'b0, in_index} >= 11'(VLEN))
                                   : (({1'b0, in_index} + 11'(CW)) > 11'(VLEN));

  // Position the incoming chunk (or mask bit) inside the register image
  always_comb begin
    field_mask = '0;
    field_data = '0;
    if (ctx_q.mask) begin
      field_mask = VLEN'(1'b1) << in_index;
      field_data = VLEN'(in_data[0]) << in_index;
    end else begin
      field_mask = VLEN'({CW{1'b1}}) << in_index;
      field_data = VLEN'(in_data[CW-1:0]) << in_index;
    end
  end

  // Next-state logic for the collect/write handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = (vl != 10'd0) ? ST_COLLECT : ST_DONE;
      ST_COLLECT: if (chunk_acc && in_last) state_d = ST_WRITE;
      ST_WRITE:   if (wb_ready) state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, latched instruction context, result buffer and sticky error
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the buffer drives wb_data directly and must read 0 out of reset, so it is reset like any other register.
    if (reset) begin
      state_q <= ST_IDLE;
      ctx_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (start_acc) begin
        ctx_q <= '{vd: vd_addr, vl: vl, vsew: vsew, mask: instr_mask};
        buf_q <= '0;
        err_q <= 1'b0;
      end else if (chunk_acc) begin
        if (out_of_range) err_q <= 1'b1;
        else              buf_q <= (buf_q & ~field_mask) | field_data;
      end
    end
  end

  rvv_be_gen #(.VLEN(VLEN)) u_be_gen (
    .vl         (ctx_q.vl),
    .vsew       (ctx_q.vsew),
    .instr_mask (ctx_q.mask),
    .be         (wb_be)
  );

  assign in_ready = (state_q == ST_COLLECT);
  assign wb_valid = (state_q == ST_WRITE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign wb_addr  = ctx_q.vd;
  assign wb_data  = buf_q;
  assign err      = err_q;

endmodule
